// File: rtl/temp_code_filter_if.sv
// Sample/result bundle between the counter stage, the code filter and its consumer.
// Valid/ready note: there is no back-pressure; a sample is offered by a rising edge on
// analog_out, and every result is a one-cycle avg_valid strobe that must be taken when seen.
interface temp_code_filter_if;
    logic        analog_out;
    logic [7:0]  b;
    logic [7:0]  avg;
    logic        avg_valid;
    logic        alarm;
    logic        stuck;
    logic [11:0] dbg_sum;

    modport master (
        output analog_out, b,
        input  avg, avg_valid, alarm, stuck, dbg_sum
    );

    modport slave (
        input  analog_out, b,
        output avg, avg_valid, alarm, stuck, dbg_sum
    );
endinterface

// File: rtl/temp_code_filter.sv
// Moving-average filter for the temperature code with start-up discard,
// hysteretic over-threshold alarm and stalled-front-end detection.
module temp_code_filter #(
    parameter int          LOG2_N  = 2,
    parameter int          DISCARD = 1,
    parameter logic [7:0]  HI_TH   = 8'd200,
    parameter logic [7:0]  LO_TH   = 8'd100,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic               clk,
    input  logic               RESET,
    temp_code_filter_if.slave  bus
);

    localparam int N   = 1 << LOG2_N;
    localparam int SW  = 8 + LOG2_N;
    localparam int WPW = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam int FW  = LOG2_N + 1;

    logic           r_a_d;
    logic           r_pend;
    logic [2:0]     r_disc;
    logic [7:0]     r_buf [N];
    logic [WPW-1:0] r_wp;
    logic [FW-1:0]  r_fill;
    logic [SW-1:0]  r_sum;
    logic           r_emit;
    logic [7:0]     r_avg;
    logic           r_avg_valid;
    logic           r_alarm;
    logic [15:0]    r_idle;
    logic           r_stuck;

    logic           w_edge;
    logic [SW-1:0]  w_sum_new;
    logic [FW-1:0]  w_fill_next;

    assign w_edge      = bus.analog_out & ~r_a_d;
    // The oldest entry is part of r_sum, so this subtraction can never underflow.
    assign w_sum_new   = r_sum + SW'(bus.b) - SW'(r_buf[r_wp]);
    assign w_fill_next = (r_fill == FW'(N)) ? r_fill : r_fill + 1'b1;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_a_d       <= 1'b0;
            r_pend      <= 1'b0;
            r_disc      <= '0;
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_wp        <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_emit      <= 1'b0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_alarm     <= 1'b0;
            r_idle      <= '0;
            r_stuck     <= 1'b0;
        end else begin
            r_a_d  <= bus.analog_out;
            r_pend <= w_edge;
            r_emit <= 1'b0;

            if (r_pend) begin
                if (r_disc != 3'(DISCARD)) begin
                    r_disc <= r_disc + 1'b1;
                end else begin
                    r_sum       <= w_sum_new;
                    r_buf[r_wp] <= bus.b;
                    r_wp        <= (r_wp == WPW'(N - 1)) ? '0 : r_wp + 1'b1;
                    r_fill      <= w_fill_next;
                    r_emit      <= (w_fill_next == FW'(N));
                end
            end

            r_avg_valid <= r_emit;
            if (r_emit) r_avg <= 8'(r_sum >> LOG2_N);

            // Hysteresis: between the thresholds the previous decision is kept.
            if (r_avg_valid) begin
                if (r_avg >= HI_TH)      r_alarm <= 1'b1;
                else if (r_avg <= LO_TH) r_alarm <= 1'b0;
            end

            if (w_edge)                 r_idle <= '0;
            else if (r_idle != TIMEOUT) r_idle <= r_idle + 1'b1;
            r_stuck <= (r_idle == TIMEOUT);
        end
    end

    assign bus.avg       = r_avg;
    assign bus.avg_valid = r_avg_valid;
    assign bus.alarm     = r_alarm;
    assign bus.stuck     = r_stuck;
    assign bus.dbg_sum   = 12'(r_sum);

endmodule
